codificador_bcd_3x2: RTL and testbench
======================================

Name: codificador_bcd_3x2

Overview:
- Registered 3-to-2 binary (BCD) encoder: three input request lines e1, e2, e3 are encoded to the 2-bit code {s1,s0} of the asserted input's index (1, 2 or 3).
- Sits between discrete request/select lines and downstream logic that consumes a compact binary code.
- Adds a valid flag and a multiple-active flag.
- Encoding style (plain OR encoder or priority encoder) is selected by parameter.

Parameters:
- PRIORITY, 0, encoding mode.
  - 0: OR encoder, s0 = e1|e3, s1 = e2|e3.
  - 1: priority encoder, highest index wins (e3 > e2 > e1).

Ports:
- clk  input  1  rising-edge clock; all outputs registered on it.
- rst_n  input  1  asynchronous active-low reset.
- e1  input  1  request line with code 1 (01).
- e2  input  1  request line with code 2 (10).
- e3  input  1  request line with code 3 (11).
- s0  output  1  code bit 0 (LSB), registered.
- s1  output  1  code bit 1 (MSB), registered.
- valid  output  1  registered; 1 when at least one of e1..e3 was high.
- multi  output  1  registered; 1 when two or more of e1..e3 were high.

Behaviour:
- Reset
  - rst_n low forces s0, s1, valid and multi to 0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while rst_n is low.
  - The first capture happens on the first rising clk edge after rst_n goes high.
- Latency
  - e1..e3 are sampled on each rising clk edge.
  - The encoded result appears on the outputs in the same edge's register update, i.e. 1 cycle of latency.
  - Outputs hold their value between edges.
  - No handshake: every edge samples the inputs.
- PRIORITY=0 truth table, inputs listed as (e1,e2,e3) -> (s1,s0):
  - 000->00, 001->11, 010->10, 011->11
  - 100->01, 101->11, 110->11, 111->11
- PRIORITY=1 truth table, inputs listed as (e1,e2,e3) -> (s1,s0):
  - e3=1 gives 11 regardless of e1 and e2.
  - Otherwise e2=1 gives 10.
  - Otherwise e1=1 gives 01.
  - Otherwise 00.
  - Only 110 differs from mode 0: it gives 10, not 11.
- valid = e1|e2|e3. With all inputs 0 the code is 00 and valid=0, which separates "no request" from any real code.
- multi = 1 for input patterns 011, 101, 110 and 111; 0 otherwise. Computed identically in both modes.
- Simultaneous events: an input change coinciding with a clock edge uses the value settled before the edge (standard setup). No glitch filtering and no input synchronization; inputs are assumed synchronous to clk.
- Reset mid-operation: outputs clear asynchronously. The last captured code is lost; sampling resumes on the first edge after release.
- No internal state beyond the four output flops.

Test Plan:
- Reset with rst_n=0 while inputs toggle -> s1,s0,valid,multi all 0. Release, then one edge with 000 -> still 0000.
- PRIORITY=0, apply each of the 8 input patterns 000..111 for one cycle each -> codes per table, each one cycle after its edge: 00,11,10,11,01,11,11,11. valid=0 only for 000. multi=1 for 011,101,110,111.
- PRIORITY=1, pattern 110 -> s1=1, s0=0, valid=1, multi=1. Pattern 101 -> 11.
- Latency check: switch inputs from 000 to 010 just before an edge -> outputs still 00 before that edge, 10 immediately after it.
- Async reset mid-stream: with outputs at 11 (pattern 111), pull rst_n low between edges -> all outputs 0 before the next edge. Release with 100 applied -> code 01, valid=1 on the next edge.

Source files
------------

// File: rtl/codificador_bcd_3x2.sv
// Registered 3-to-2 encoder for request lines e1..e3, with valid and multiple-active flags.
// PRIORITY selects a plain OR encoder (0) or a highest-index-wins priority encoder (1).
module codificador_bcd_3x2 #(
  parameter int unsigned PRIORITY = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic e1,
  input  logic e2,
  input  logic e3,
  output logic s0,
  output logic s1,
  output logic valid,
  output logic multi
);

  logic [1:0] code_d, code_q;
  logic       valid_d, valid_q;
  logic       multi_d, multi_q;

  always_comb begin
    code_d = 2'b00;
    if (PRIORITY != 0) begin
      if (e3) begin
        code_d = 2'b11;
      end else if (e2) begin
        code_d = 2'b10;
      end else if (e1) begin
        code_d = 2'b01;
      end
    end else begin
      code_d = {e2 | e3, e1 | e3};
    end
    valid_d = e1 | e2 | e3;
    // Two or more lines high: any pairwise AND.
    multi_d = (e1 & e2) | (e1 & e3) | (e2 & e3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign s0    = code_q[0];
  assign s1    = code_q[1];
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_codificador_bcd_3x2.sv
// Bench for codificador_bcd_3x2: both encoding modes share the inputs; expected
// {s1,s0,valid,multi} words are queued on drive and popped after the capturing edge.
module tb_codificador_bcd_3x2;

  logic clk;
  logic rst_n;
  logic e1, e2, e3;
  logic s0_a, s1_a, valid_a, multi_a;
  logic s0_b, s1_b, valid_b, multi_b;

  codificador_bcd_3x2 #(.PRIORITY(0)) u_dut_or (
    .clk   (clk),
    .rst_n (rst_n),
    .e1    (e1),
    .e2    (e2),
    .e3    (e3),
    .s0    (s0_a),
    .s1    (s1_a),
    .valid (valid_a),
    .multi (multi_a)
  );

  codificador_bcd_3x2 #(.PRIORITY(1)) u_dut_pri (
    .clk   (clk),
    .rst_n (rst_n),
    .e1    (e1),
    .e2    (e2),
    .e3    (e3),
    .s0    (s0_b),
    .s1    (s1_b),
    .valid (valid_b),
    .multi (multi_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] exp_or;
    logic [3:0] exp_pri;
  } sb_item_t;

  sb_item_t   sb_q[$];
  int         tests;
  int         fails;
  logic [1:0] tbl_or  [8];
  logic [1:0] tbl_pri [8];
  logic [2:0] pat;

  // Independent reference: truth tables indexed by {e1,e2,e3}.
  function automatic logic [3:0] model(input logic [2:0] p, input logic pri);
    logic [1:0] code;
    logic       v;
    logic       m;
    code = pri ? tbl_pri[p] : tbl_or[p];
    v    = (p != 3'b000);
    m    = (p == 3'b011) || (p == 3'b101) || (p == 3'b110) || (p == 3'b111);
    return {code, v, m};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed {s1,s0,valid,multi}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [3:0] exp_or,
                            input logic [3:0] exp_pri);
    check({tag, "/or"}, {s1_a, s0_a, valid_a, multi_a}, exp_or);
    check({tag, "/pri"}, {s1_b, s0_b, valid_b, multi_b}, exp_pri);
  endtask

  task automatic push(input string tag, input logic [2:0] p);
    sb_item_t it;
    it.tag     = tag;
    it.exp_or  = model(p, 1'b0);
    it.exp_pri = model(p, 1'b1);
    sb_q.push_back(it);
  endtask

  task automatic pop_and_check();
    sb_item_t it;
    tests++;
    assert (sb_q.size() > 0) else begin
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    tests--;
    it = sb_q.pop_front();
    check_both(it.tag, it.exp_or, it.exp_pri);
  endtask

  task automatic drive(input logic [2:0] p);
    {e1, e2, e3} = p;
  endtask

  task automatic step(input string tag, input logic [2:0] p);
    @(negedge clk);
    drive(p);
    push(tag, p);
    @(posedge clk);
    #1;
    pop_and_check();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tbl_or  = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    tbl_pri = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
    rst_n = 1'b0;
    drive(3'b000);

    // Held in reset while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat = 3'(i * 3 + 1);
      drive(pat);
      @(posedge clk);
      #1;
      check_both("reset_hold", 4'b0000, 4'b0000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    step("release_000", 3'b000);

    // All eight patterns, one cycle each.
    for (int i = 0; i < 8; i++) begin
      pat = 3'(i);
      step($sformatf("pat_%03b", pat), pat);
    end

    step("pri_110", 3'b110);
    step("pri_101", 3'b101);

    // Latency: change to 010 just before an edge.
    step("lat_000", 3'b000);
    @(negedge clk);
    #3;
    drive(3'b010);
    push("lat_010_after", 3'b010);
    #1;
    check_both("lat_before_edge", 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    pop_and_check();

    // Asynchronous reset between edges.
    step("pre_rst_111", 3'b111);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_both("async_rst", 4'b0000, 4'b0000);
    #1;
    drive(3'b100);
    rst_n = 1'b1;
    push("post_rst_100", 3'b100);
    #1;
    check_both("rst_released_pre_edge", 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    pop_and_check();

    step("final_011", 3'b011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
